// File: rtl/fpmul_issue_ctrl_pkg.sv
// Shared constants and types for the FP multiplier issue controller.
package fpmul_issue_ctrl_pkg;

    // Index width for a requester count; a single requester still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FPMUL_LATENCY = 2;
    localparam int FPMUL_NUM_REQ = 2;
    localparam int FPMUL_TAG_W   = 5;
    localparam int FPMUL_ID_W    = idx_width(FPMUL_NUM_REQ);

    // One multiplier pipeline stage as seen by the controller.
    typedef struct packed {
        logic                   v;
        logic [FPMUL_ID_W-1:0]  id;
        logic [FPMUL_TAG_W-1:0] tag;
    } fpmul_stage_t;

endpackage

// File: rtl/fpmul_issue_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) wins.
module fpmul_issue_ctrl_rr_arbiter
    import fpmul_issue_ctrl_pkg::*;
#(
    parameter int NUM_REQ = FPMUL_NUM_REQ,
    parameter int ID_W    = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    int               idx;
    logic [ID_W-1:0]  sel;

    // Search ptr, ptr+1, ... with an explicit wrap so non-power-of-2 counts never index past the end.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = ID_W'(idx);
            if (!gnt_any && req[sel]) begin
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpmul_issue_ctrl.sv
// Issue controller for the shared pipelined FP multiplier: arbitration, stage tracking and output handshake.
module fpmul_issue_ctrl
    import fpmul_issue_ctrl_pkg::*;
#(
    parameter int NUM_REQ = FPMUL_NUM_REQ,
    parameter int LATENCY = FPMUL_LATENCY,
    parameter int TAG_W   = FPMUL_TAG_W,
    localparam int ID_W   = idx_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          flush,
    output logic                          mul_en,
    output logic [LATENCY-1:0]            mul_clear,
    output logic [ID_W-1:0]               mul_sel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ID_W-1:0]               out_req_id,
    output logic [TAG_W-1:0]              out_tag,
    output logic                          busy
);

    logic [LATENCY-1:0]            v_q, v_d;
    logic [LATENCY-1:0][ID_W-1:0]  id_q, id_d;
    logic [LATENCY-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;

    // Pipeline advances unless flushing, in reset, or the final result is stuck waiting downstream.
    always_comb begin
        mul_en  = rst_n && !flush && (out_ready || !v_q[LATENCY-1]);
        arb_req = req_valid & {NUM_REQ{mul_en}};
    end

    fpmul_issue_ctrl_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (arb_req),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // Datapath controls and output view of the final stage.
    always_comb begin
        req_ready  = arb_gnt;
        mul_sel    = arb_idx;
        mul_clear  = '0;
        if (!rst_n || flush) begin
            mul_clear = '1;
        end else if (mul_en && !arb_any) begin
            mul_clear[LATENCY-1] = 1'b1;
        end
        out_valid  = v_q[LATENCY-1];
        out_req_id = id_q[LATENCY-1];
        out_tag    = tag_q[LATENCY-1];
        busy       = |v_q;
    end

    // Next-state: flush empties every stage; an advance shifts and loads stage 0 with the grant or a bubble.
    always_comb begin
        v_d      = v_q;
        id_d     = id_q;
        tag_d    = tag_q;
        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            v_d = '0;
        end else if (mul_en) begin
            for (int k = 1; k < LATENCY; k++) begin
                v_d[k]   = v_q[k-1];
                id_d[k]  = id_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
            v_d[0] = arb_any;
            if (arb_any) begin
                id_d[0]  = arb_idx;
                tag_d[0] = req_tag[arb_idx];
                rr_ptr_d = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q      <= '0;
            id_q     <= '0;
            tag_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            v_q      <= v_d;
            id_q     <= id_d;
            tag_q    <= tag_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
